// File: rtl/fraction_mult_pkg.sv
// Shared types and constants for the Q1.3 x Q1.3 fraction multiply sequencer.
// Operand pairs travel through the FIFO packed as {mplier, mcand}.
package fraction_mult_pkg;

  localparam int FRAC_IN_W  = 4;
  localparam int FRAC_OUT_W = 7;

  localparam logic [FRAC_IN_W-1:0]  FRAC_MIN_IN  = 4'b1000;
  localparam logic [FRAC_OUT_W-1:0] FRAC_SAT_OUT = 7'b0111111;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT
  } seq_state_t;

  typedef struct packed {
    logic [FRAC_IN_W-1:0] mplier;
    logic [FRAC_IN_W-1:0] mcand;
  } frac_pair_t;

  // -1 x -1 is the only product that overflows Q1.6
  function automatic logic frac_is_sat(frac_pair_t p);
    return (p.mplier == FRAC_MIN_IN) && (p.mcand == FRAC_MIN_IN);
  endfunction

endpackage

// File: rtl/frac_operand_fifo.sv
// Small operand FIFO, 8-bit entries, extra pointer bit for full/empty.
// Pushes while full and pops while empty are ignored.
module frac_operand_fifo #(
  parameter int DEPTH = 2
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic          do_push;
  logic          do_pop;

  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);
  assign empty = (wp == rp);

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rp[AW-1:0]];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wp <= '0;
      rp <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wp[AW-1:0]] <= wdata;
        wp <= wp + PW'(1);
      end
      if (do_pop)
        rp <= rp + PW'(1);
    end
  end

endmodule

// File: rtl/fraction_mult_sequencer.sv
// Issues buffered operand pairs to fraction_multiplier4 and captures
// its product into a valid/ready result register, with watchdog.
module fraction_mult_sequencer
  import fraction_mult_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [FRAC_IN_W-1:0]  in_mplier,
  input  logic [FRAC_IN_W-1:0]  in_mcand,
  output logic                  mul_st,
  output logic [FRAC_IN_W-1:0]  mul_mplier,
  output logic [FRAC_IN_W-1:0]  mul_mcand,
  input  logic [FRAC_OUT_W-1:0] mul_product,
  input  logic                  mul_done,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FRAC_OUT_W-1:0] out_product,
  output logic                  out_sat,
  output logic                  out_err
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  seq_state_t state;
  seq_state_t state_nxt;
  frac_pair_t op_reg;
  logic [7:0] fifo_rdata;
  logic [CW-1:0] cnt;
  logic full;
  logic empty;
  logic done_q;
  logic done_armed;
  logic done_rise;
  logic res_free;
  logic pop;
  logic capture;
  logic tmo;

  assign in_ready   = ~full;
  assign res_free   = ~out_valid | out_ready;
  assign done_rise  = mul_done & ~done_q;
  assign mul_mplier = op_reg.mplier;
  assign mul_mcand  = op_reg.mcand;

  frac_operand_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RST_N (RST_N),
    .push  (in_valid & in_ready),
    .pop   (pop),
    .wdata ({in_mplier, in_mcand}),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (pop) state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT:    if (capture | tmo) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pop     = 1'b0;
    capture = 1'b0;
    tmo     = 1'b0;
    unique case (state)
      IDLE: pop = ~empty & res_free & done_armed;
      WAIT: begin
        capture = done_rise;
        tmo     = ~done_rise & (cnt == CNT_MAX);
      end
      default: ;
    endcase
  end

  // A Done still high from before reset must drop once before use
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      done_q     <= 1'b1;
      done_armed <= 1'b0;
    end else begin
      done_q     <= mul_done;
      done_armed <= done_armed | ~mul_done;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mul_st <= 1'b0;
      op_reg <= '0;
      cnt    <= '0;
    end else begin
      mul_st <= pop;
      if (pop)
        op_reg <= frac_pair_t'(fifo_rdata);
      if (state == START)
        cnt <= '0;
      else if (state == WAIT)
        cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_valid   <= 1'b0;
      out_product <= '0;
      out_sat     <= 1'b0;
      out_err     <= 1'b0;
    end else if (capture) begin
      out_valid   <= 1'b1;
      out_sat     <= frac_is_sat(op_reg);
      out_err     <= 1'b0;
      out_product <= frac_is_sat(op_reg) ?
                     FRAC_SAT_OUT : mul_product;
    end else if (tmo) begin
      out_valid   <= 1'b1;
      out_product <= '0;
      out_sat     <= 1'b0;
      out_err     <= 1'b1;
    end else if (out_valid & out_ready) begin
      out_valid   <= 1'b0;
      out_product <= '0;
      out_sat     <= 1'b0;
      out_err     <= 1'b0;
    end
  end

endmodule
